// File: rtl/preg_freelist_pkg.sv
// rtl/preg_freelist_pkg.sv - shared sizes and types for the physical-register free list
package preg_freelist_pkg;

    localparam int CWD   = 4;
    localparam int RWD   = 4;
    localparam int PRN   = 96;
    localparam int NLREG = 32;
    localparam int FSZ   = PRN - NLREG;
    localparam int PW    = $clog2(PRN);
    localparam int FW    = $clog2(FSZ);
    localparam int AW    = $clog2(RWD + 1);
    localparam int LW    = $clog2(NLREG);

    typedef logic [PW-1:0] preg_t;
    typedef logic [LW-1:0] lreg_t;
    typedef logic [FW:0]   ptr_t;
    typedef logic [FW-1:0] idx_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef struct packed {
        logic [15:0] opid;
        lreg_t       lrda;
        preg_t       prda;
        logic        redir;
        logic        rollback;
    } com_bundle_t;

    localparam int CB_W = $bits(com_bundle_t);

    function automatic idx_t ptr_idx(input ptr_t p);
        return p[FW-1:0];
    endfunction

endpackage

// File: rtl/preg_freelist_buf.sv
// rtl/preg_freelist_buf.sv - free-list slot storage: flop array, reset to pregs NLREG..PRN-1
module preg_freelist_buf
    import preg_freelist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CWD-1:0]    i_we,
    input  idx_t [CWD-1:0]    i_waddr,
    input  preg_t [CWD-1:0]   i_wdata,
    input  idx_t [RWD-1:0]    i_raddr,
    output preg_t [RWD-1:0]   o_rdata
);

    preg_t [FSZ-1:0] r_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < FSZ; k++) begin
                r_mem[k] <= preg_t'(NLREG + k);
            end
        end else begin
            for (int w = 0; w < CWD; w++) begin
                if (i_we[w]) begin
                    r_mem[i_waddr[w]] <= i_wdata[w];
                end
            end
        end
    end

    for (genvar r = 0; r < RWD; r++) begin : g_rd
        assign o_rdata[r] = r_mem[i_raddr[r]];
    end

endmodule

// File: rtl/preg_freelist.sv
// rtl/preg_freelist.sv - preg free list with committed rename table, fed by the commit bundle
// head = speculative alloc, chead = committed alloc, tail = release; all pointers carry a wrap bit.
module preg_freelist
    import preg_freelist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CWD*CB_W-1:0]   com_bundle,
    input  logic [AW-1:0]         alloc_num,
    output logic                  alloc_rdy,
    output logic [RWD*PW-1:0]     alloc_preg,
    output logic [FW:0]           free_cnt,
    output logic [NLREG*PW-1:0]   crat
);

    com_bundle_t [CWD-1:0] w_cb;
    preg_t [NLREG-1:0]     r_crat;
    preg_t [NLREG-1:0]     w_crat_nx;
    ptr_t                  r_head, r_chead, r_tail;
    ptr_t                  w_head_nx, w_chead_nx, w_tail_nx;
    ptr_t                  w_nw, w_nrb, w_alloc, w_free;
    logic                  r_last_v, w_last_v_nx;
    lreg_t                 r_last_lrda, w_last_lrda_nx;
    preg_t                 r_last_old, w_last_old_nx;
    logic                  w_lastroll, w_other_rb, w_any_act;
    logic                  w_unused_bits;
    logic [CWD-1:0]        w_we;
    idx_t [CWD-1:0]        w_waddr;
    preg_t [CWD-1:0]       w_wdata;
    idx_t [RWD-1:0]        w_raddr;
    preg_t [RWD-1:0]       w_rdata;

    assign w_cb       = com_bundle;
    assign w_alloc    = ptr_t'(alloc_num);
    assign w_free     = r_tail - r_head;
    assign free_cnt   = w_free;
    assign alloc_rdy  = (w_free >= ptr_t'(RWD));
    assign crat       = r_crat;
    assign alloc_preg = w_rdata;

    for (genvar r = 0; r < RWD; r++) begin : g_raddr
        assign w_raddr[r] = ptr_idx(r_head + ptr_t'(r));
    end

    preg_freelist_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // A lone rollback whose prda is the current committed mapping can only undo the last commit.
    always_comb begin
        w_other_rb    = 1'b0;
        w_unused_bits = w_cb[0].opid[0];
        for (int i = 1; i < CWD; i++) begin
            w_other_rb    = w_other_rb | w_cb[i].rollback;
            w_unused_bits = w_unused_bits ^ w_cb[i].redir;
        end
        for (int i = 0; i < CWD; i++) begin
            w_unused_bits = w_unused_bits ^ (^w_cb[i].opid[14:0]);
        end
        w_lastroll = w_cb[0].rollback && !w_other_rb && r_last_v &&
                     (w_cb[0].lrda == r_last_lrda) &&
                     (w_cb[0].prda == r_crat[w_cb[0].lrda]);
    end

    always_comb begin
        w_crat_nx      = r_crat;
        w_nw           = '0;
        w_nrb          = '0;
        w_any_act      = 1'b0;
        w_we           = '0;
        w_waddr        = '0;
        w_wdata        = '0;
        w_last_v_nx    = r_last_v;
        w_last_lrda_nx = r_last_lrda;
        w_last_old_nx  = r_last_old;
        for (int i = 0; i < CWD; i++) begin
            w_any_act = w_any_act | w_cb[i].opid[15] | w_cb[i].rollback;
            if (w_cb[i].opid[15] && !w_cb[i].rollback && (w_cb[i].lrda != '0)) begin
                w_we[i]                  = 1'b1;
                w_waddr[i]               = ptr_idx(r_tail + w_nw);
                w_wdata[i]               = w_crat_nx[w_cb[i].lrda];
                w_crat_nx[w_cb[i].lrda]  = w_cb[i].prda;
                w_last_v_nx              = 1'b1;
                w_last_lrda_nx           = w_cb[i].lrda;
                w_last_old_nx            = w_wdata[i];
                w_nw                     = w_nw + PTR_ONE;
            end
            if (w_cb[i].rollback && !w_cb[i].opid[15] && (w_cb[i].lrda != '0)) begin
                w_nrb = w_nrb + PTR_ONE;
            end
        end
        if ((w_nw == '0) && w_any_act) begin
            w_last_v_nx = 1'b0;
        end
        w_chead_nx = r_chead + w_nw;
        w_tail_nx  = r_tail + w_nw;
        w_head_nx  = r_head - w_nrb + w_alloc;
        if (w_lastroll) begin
            // slot head-1 aliases the withdrawn push, so put prda back there explicitly
            w_crat_nx[w_cb[0].lrda] = r_last_old;
            w_we[0]                 = 1'b1;
            w_waddr[0]              = ptr_idx(r_head - PTR_ONE);
            w_wdata[0]              = w_cb[0].prda;
            w_chead_nx              = r_chead - PTR_ONE;
            w_tail_nx               = r_tail - PTR_ONE;
            w_head_nx               = r_head - PTR_ONE + w_alloc;
        end
        if (w_cb[0].redir) begin
            w_head_nx = w_chead_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NLREG; i++) begin
                r_crat[i] <= preg_t'(i);
            end
            r_head      <= '0;
            r_chead     <= '0;
            r_tail      <= ptr_t'(FSZ);
            r_last_v    <= 1'b0;
            r_last_lrda <= '0;
            r_last_old  <= '0;
        end else begin
            r_crat      <= w_crat_nx;
            r_head      <= w_head_nx;
            r_chead     <= w_chead_nx;
            r_tail      <= w_tail_nx;
            r_last_v    <= w_last_v_nx;
            r_last_lrda <= w_last_lrda_nx;
            r_last_old  <= w_last_old_nx;
        end
    end

    assert property (@(posedge clk) disable iff (!rst) (w_alloc <= w_free));
    assert property (@(posedge clk) disable iff (!rst) (w_free <= ptr_t'(FSZ)));
    assert property (@(posedge clk) disable iff (!rst) ((r_head - r_chead) <= ptr_t'(FSZ)));

endmodule

// File: tb/tb_preg_freelist.sv
// tb/tb_preg_freelist.sv - self-checking bench: vector table, directed corners, random vs queue model
module tb_preg_freelist;
    import preg_freelist_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    com_bundle_t [CWD-1:0] cbp;
    logic [CWD*CB_W-1:0]   com_bundle;
    logic [AW-1:0]         alloc_num;
    logic                  alloc_rdy;
    logic [RWD*PW-1:0]     alloc_preg;
    logic [FW:0]           free_cnt;
    logic [NLREG*PW-1:0]   crat;

    assign com_bundle = cbp;
    always #5 clk = ~clk;

    preg_freelist dut (
        .clk        (clk),
        .rst        (rst),
        .com_bundle (com_bundle),
        .alloc_num  (alloc_num),
        .alloc_rdy  (alloc_rdy),
        .alloc_preg (alloc_preg),
        .free_cnt   (free_cnt),
        .crat       (crat)
    );

    int n_err = 0;
    int n_chk = 0;

    // model: free list and in-flight allocations as ordered queues of preg numbers
    int q_free[$];
    int q_infl[$];
    int m_crat[NLREG];
    bit m_last_v;
    int m_last_lrda, m_last_old;

    typedef struct {
        int alloc;
        int exp_free;
        int exp_rdy;
        int exp_p0;
    } vec_t;
    vec_t tbl[17];

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int preg_at(input int i);
        return int'(alloc_preg[i*PW +: PW]);
    endfunction

    function automatic int crat_at(input int i);
        return int'(crat[i*PW +: PW]);
    endfunction

    function automatic void model_reset();
        q_free.delete();
        q_infl.delete();
        for (int k = 0; k < FSZ; k++) q_free.push_back(NLREG + k);
        for (int i = 0; i < NLREG; i++) m_crat[i] = i;
        m_last_v = 0;
        m_last_lrda = 0;
        m_last_old = 0;
    endfunction

    function automatic void model_step();
        int  olds[$];
        int  nw = 0;
        int  k = 0;
        bit  any = 0;
        bit  other_rb = 0;
        bit  lastroll;
        int  prev_old = m_last_old;
        int  l0 = int'(cbp[0].lrda);
        for (int i = 1; i < CWD; i++) other_rb |= cbp[i].rollback;
        lastroll = cbp[0].rollback && !other_rb && m_last_v && (l0 == m_last_lrda) &&
                   (int'(cbp[0].prda) == m_crat[l0]);
        for (int i = 0; i < CWD; i++) begin
            int l = int'(cbp[i].lrda);
            any |= cbp[i].opid[15] | cbp[i].rollback;
            if (cbp[i].opid[15] && !cbp[i].rollback && l != 0) begin
                olds.push_back(m_crat[l]);
                m_crat[l] = int'(cbp[i].prda);
                m_last_lrda = l;
                m_last_old = olds[olds.size()-1];
                nw++;
            end
            if (cbp[i].rollback && !cbp[i].opid[15] && l != 0) k++;
        end
        if (nw > 0) m_last_v = 1;
        else if (any) m_last_v = 0;
        if (lastroll) begin
            m_crat[l0] = prev_old;
            void'(q_free.pop_back());
            q_free.push_front(int'(cbp[0].prda));
        end else begin
            for (int j = 0; j < k; j++) q_free.push_front(q_infl.pop_back());
        end
        for (int j = 0; j < nw; j++) void'(q_infl.pop_front());
        foreach (olds[j]) q_free.push_back(olds[j]);
        if (cbp[0].redir) begin
            while (q_infl.size() > 0) q_free.push_front(q_infl.pop_back());
        end else begin
            for (int j = 0; j < int'(alloc_num); j++) q_infl.push_back(q_free.pop_front());
        end
    endfunction

    function automatic void check_model(input string tag);
        int n = q_free.size();
        chk({tag, "_free_cnt"}, int'(free_cnt), n);
        chk({tag, "_alloc_rdy"}, int'(alloc_rdy), int'(n >= RWD));
        for (int i = 0; i < RWD && i < n; i++) chk({tag, "_alloc_preg"}, preg_at(i), q_free[i]);
        for (int i = 0; i < NLREG; i++) chk({tag, "_crat"}, crat_at(i), m_crat[i]);
    endfunction

    function automatic void dup_check();
        bit seen[128];
        bit dup = 0;
        int v;
        for (int i = 0; i < NLREG; i++) begin
            v = crat_at(i);
            if (v >= PRN || seen[v]) dup = 1;
            seen[v] = 1;
        end
        for (int i = 0; i < RWD && i < int'(free_cnt); i++) begin
            v = preg_at(i);
            if (v >= PRN || seen[v]) dup = 1;
            seen[v] = 1;
        end
        chk("no_duplicate_preg", int'(dup), 0);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cbp = '0;
        alloc_num = '0;
    endtask

    task automatic do_reset();
        cbp = '0;
        alloc_num = '0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_wr(input int lane, input int lrda, input int prda);
        cbp[lane].opid[15] = 1'b1;
        cbp[lane].lrda     = lreg_t'(lrda);
        cbp[lane].prda     = preg_t'(prda);
    endtask

    task automatic set_rb(input int lane, input int lrda, input int prda);
        cbp[lane].rollback = 1'b1;
        cbp[lane].lrda     = lreg_t'(lrda);
        cbp[lane].prda     = preg_t'(prda);
    endtask

    initial begin
        cbp = '0;
        alloc_num = '0;
        #3;
        for (int j = 0; j < 16; j++) tbl[j] = '{4, FSZ - 4*j, 1, NLREG + 4*j};
        tbl[16] = '{0, 0, 0, -1};

        do_reset();
        chk("reset_free_cnt", int'(free_cnt), 64);
        chk("reset_alloc_rdy", int'(alloc_rdy), 1);
        check_model("reset");

        foreach (tbl[j]) begin
            chk("tbl_free_cnt", int'(free_cnt), tbl[j].exp_free);
            chk("tbl_alloc_rdy", int'(alloc_rdy), tbl[j].exp_rdy);
            if (tbl[j].exp_p0 >= 0)
                for (int i = 0; i < RWD; i++) chk("tbl_alloc_preg", preg_at(i), tbl[j].exp_p0 + i);
            alloc_num = AW'(tbl[j].alloc);
            tick();
        end
        check_model("drain");

        do_reset();
        alloc_num = 2;
        tick();
        chk("fwd_free_after_alloc", int'(free_cnt), 62);
        set_wr(0, 5, 32);
        set_wr(1, 5, 33);
        set_wr(2, 0, 40);
        tick();
        chk("fwd_crat5", crat_at(5), 33);
        chk("fwd_free_after_commit", int'(free_cnt), 64);
        for (int j = 0; j < 15; j++) begin
            alloc_num = 4;
            tick();
        end
        alloc_num = 2;
        tick();
        chk("fwd_push0", preg_at(0), 5);
        chk("fwd_push1", preg_at(1), 32);
        check_model("fwd");

        do_reset();
        alloc_num = 4;
        tick();
        set_wr(0, 1, 32);
        set_wr(1, 2, 33);
        tick();
        chk("redir_pre_p0", preg_at(0), 36);
        cbp[0].redir = 1'b1;
        alloc_num = 3;
        tick();
        chk("redir_p0", preg_at(0), 34);
        chk("redir_free", int'(free_cnt), 64);
        check_model("redir");

        do_reset();
        alloc_num = 3;
        tick();
        chk("rb_pre_p0", preg_at(0), 35);
        set_rb(0, 1, 34);
        set_rb(1, 2, 33);
        set_rb(2, 3, 32);
        tick();
        chk("rb_free", int'(free_cnt), 64);
        for (int i = 0; i < 3; i++) chk("rb_reoffer", preg_at(i), 32 + i);
        alloc_num = 3;
        tick();
        set_rb(0, 4, 34);
        set_rb(1, 5, 33);
        alloc_num = 1;
        tick();
        chk("rb_alloc_free", int'(free_cnt), 62);
        chk("rb_alloc_p0", preg_at(0), 34);
        check_model("rb");

        do_reset();
        alloc_num = 1;
        tick();
        set_wr(0, 7, 32);
        tick();
        chk("lr_commit_crat7", crat_at(7), 32);
        set_rb(0, 7, 32);
        tick();
        chk("lr_crat7", crat_at(7), 7);
        chk("lr_free", int'(free_cnt), 64);
        chk("lr_p0", preg_at(0), 32);
        check_model("lastroll");

        do_reset();
        for (int c = 0; c < 200; c++) begin
            int op = $urandom_range(0, 9);
            int nf = q_free.size();
            int ni = q_infl.size();
            int am = (nf < RWD) ? nf : RWD;
            int nw;
            if (op == 0) begin
                nw = $urandom_range(0, (ni < 2) ? ni : 2);
                for (int j = 0; j < nw; j++) set_wr(j, $urandom_range(1, 31), q_infl[j]);
                cbp[0].redir = 1'b1;
            end else if (op <= 2 && ni > 0) begin
                int k = $urandom_range(1, (ni < CWD) ? ni : CWD);
                for (int j = 0; j < k; j++) set_rb(j, $urandom_range(1, 31), q_infl[ni-1-j]);
            end else begin
                nw = $urandom_range(0, (ni < CWD) ? ni : CWD);
                for (int j = 0; j < nw; j++) set_wr(j, $urandom_range(1, 31), q_infl[j]);
                for (int j = nw; j < CWD; j++)
                    if ($urandom_range(0, 3) == 0) set_wr(j, 0, $urandom_range(0, PRN-1));
            end
            alloc_num = AW'($urandom_range(0, am));
            tick();
            check_model("rnd");
            dup_check();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
